// File: rtl/fp_mul_collect.sv
// Result-collection FIFO behind fp_mul: first-word-fall-through queue of {flags, product}
// with sticky exception status. Optional flush-to-zero of underflowed products via FP_COLLECT_FTZ_EN.
module fp_mul_collect #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [15:0]   product,
    input  logic          underflow,
    input  logic          overflow,
    input  logic          inexact,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_product,
    output logic [2:0]    out_flags,
    output logic [CW-1:0] count,
    output logic          full,
    input  logic          flag_clr,
    output logic [3:0]    sticky_flags
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic [3:0]    sticky_reg, sticky_next;
    logic [18:0]   mem_reg [DEPTH];
    logic [18:0]   head;
    logic [15:0]   store_product;
    logic          pop, push, drop;

`ifdef FP_COLLECT_FTZ_EN
    assign store_product = underflow ? {product[15], 15'b0} : product;
`else
    assign store_product = product;
`endif

    assign out_valid    = (count_reg != '0);
    assign full         = (count_reg == CW'(DEPTH));
    assign count        = count_reg;
    assign sticky_flags = sticky_reg;

    // A pop in the same cycle frees the slot the incoming result lands in.
    assign pop  = out_valid & out_ready;
    assign push = in_valid & (~full | pop);
    assign drop = in_valid & full & ~pop;

    assign head        = mem_reg[rd_ptr_reg];
    assign out_product = out_valid ? head[15:0]  : 16'h0000;
    assign out_flags   = out_valid ? head[18:16] : 3'b000;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        sticky_next = flag_clr ? 4'b0000 : sticky_reg;
        if (pop)
            rd_ptr_next = rd_ptr_reg + PW'(1);
        if (push)
            wr_ptr_next = wr_ptr_reg + PW'(1);
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
        // Set events are applied after the clear so they win in the same cycle.
        if (push)
            sticky_next[2:0] = sticky_next[2:0] | {underflow, overflow, inexact};
        if (drop)
            sticky_next[3] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            sticky_reg <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            sticky_reg <= sticky_next;
        end
    end

    // Storage is not reset; emptiness is tracked by count alone.
    always_ff @(posedge clk) begin
        if (reset && push)
            mem_reg[wr_ptr_reg] <= {underflow, overflow, inexact, store_product};
    end
endmodule
